// File: rtl/mem_copy_pkg.sv
// Shared types for the memory copy/fill engine: FSM states and command modes.
package mem_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FILL,
        S_DONE
    } state_t;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } mode_t;

endpackage

// File: rtl/mem_port_mux.sv
// Combinational 2:1 selection of the data-memory port between the processor
// and the copy engine; the engine wins whenever it is busy.
module mem_port_mux #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         sel_engine,
    input  logic [A-1:0] cpu_addr,
    input  logic         cpu_we,
    input  logic [W-1:0] cpu_data,
    input  logic [A-1:0] eng_addr,
    input  logic         eng_we,
    input  logic [W-1:0] eng_data,
    output logic [A-1:0] mem_addr,
    output logic         mem_we,
    output logic [W-1:0] mem_data
);

    always_comb begin
        mem_addr = cpu_addr;
        mem_we   = cpu_we;
        mem_data = cpu_data;
        if (sel_engine) begin
            mem_addr = eng_addr;
            mem_we   = eng_we;
            mem_data = eng_data;
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy / fill engine sitting in front of the single-port data memory.
// Copies one byte every two cycles (read then write) or fills one byte per cycle.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Mode,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    input  logic [W-1:0] FillVal,
    input  logic [A-1:0] CpuAddr,
    input  logic         CpuWriteEn,
    input  logic [W-1:0] CpuDataIn,
    output logic [W-1:0] CpuDataOut,
    output logic [A-1:0] MemAddr,
    output logic         MemWriteEn,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut,
    output logic         Busy,
    output logic         Done
);

    state_t       state_q, state_d;
    mode_t        mode_q, mode_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] len_q, len_d;
    logic [W-1:0] fill_q, fill_d;
    logic [A-1:0] i_q, i_d;
    logic [W-1:0] buf_q, buf_d;

    logic [A-1:0] eng_addr;
    logic         eng_we;
    logic [W-1:0] eng_data;
    logic         busy;
    logic         done;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            i_q     <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            i_q     <= i_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        fill_d   = fill_q;
        i_d      = i_q;
        buf_d    = buf_q;
        eng_addr = dst_q + i_q;
        eng_we   = 1'b0;
        eng_data = (mode_q == FILL) ? fill_q : buf_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d = mode_t'(Mode);
                    src_d  = SrcAddr;
                    dst_d  = DstAddr;
                    len_d  = Len;
                    fill_d = FillVal;
                    i_d    = '0;
                    if (Len == '0)
                        state_d = S_DONE;
                    else if (mode_t'(Mode) == FILL)
                        state_d = S_FILL;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                busy     = 1'b1;
                eng_addr = src_q + i_q;
                buf_d    = MemDataOut;
                state_d  = S_WR;
            end
            S_WR: begin
                busy   = 1'b1;
                eng_we = 1'b1;
                i_d    = i_q + 1'b1;
                state_d = (i_q + 1'b1 == len_q) ? S_DONE : S_RD;
            end
            S_FILL: begin
                busy   = 1'b1;
                eng_we = 1'b1;
                i_d    = i_q + 1'b1;
                state_d = (i_q + 1'b1 == len_q) ? S_DONE : S_FILL;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    mem_port_mux #(
        .W(W),
        .A(A)
    ) u_port_mux (
        .sel_engine (busy),
        .cpu_addr   (CpuAddr),
        .cpu_we     (CpuWriteEn),
        .cpu_data   (CpuDataIn),
        .eng_addr   (eng_addr),
        .eng_we     (eng_we),
        .eng_data   (eng_data),
        .mem_addr   (MemAddr),
        .mem_we     (MemWriteEn),
        .mem_data   (MemDataIn)
    );

    assign CpuDataOut = MemDataOut;
    assign Busy       = busy;
    assign Done       = done;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: a 256x8 memory model behind the engine, and a reference
// byte array updated with plain loops from each command's copy/fill rules.
module tb_mem_copy_engine;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic       Mode;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [7:0] Len;
    logic [7:0] FillVal;
    logic [7:0] CpuAddr;
    logic       CpuWriteEn;
    logic [7:0] CpuDataIn;
    logic [7:0] CpuDataOut;
    logic [7:0] MemAddr;
    logic       MemWriteEn;
    logic [7:0] MemDataIn;
    logic [7:0] MemDataOut;
    logic       Busy;
    logic       Done;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int         write_count = 0;
    int         check_count = 0;
    int         pass_count  = 0;

    mem_copy_engine #(.W(8), .A(8)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Mode       (Mode),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Len        (Len),
        .FillVal    (FillVal),
        .CpuAddr    (CpuAddr),
        .CpuWriteEn (CpuWriteEn),
        .CpuDataIn  (CpuDataIn),
        .CpuDataOut (CpuDataOut),
        .MemAddr    (MemAddr),
        .MemWriteEn (MemWriteEn),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemDataOut = mem[MemAddr];

    always @(posedge Clk) begin
        if (MemWriteEn) begin
            mem[MemAddr] <= MemDataIn;
            write_count  <= write_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        else
            pass_count++;
    endtask

    task automatic checkMemory(input string tag);
        for (int k = 0; k < 256; k++)
            checkOutput($sformatf("%s mem[%0h]", tag, k), 32'(mem[k]), 32'(ref_mem[k]));
    endtask

    // Reference behaviour: ascending byte-by-byte, addresses wrap at 256.
    task automatic modelCommand(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                                input logic [7:0] fill, input int nbytes);
        logic [7:0] s, d;
        for (int k = 0; k < nbytes; k++) begin
            s = src + 8'(k);
            d = dst + 8'(k);
            ref_mem[d] = mode ? fill : ref_mem[s];
        end
    endtask

    task automatic startCmd(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] len, input logic [7:0] fill);
        Mode    = mode;
        SrcAddr = src;
        DstAddr = dst;
        Len     = len;
        FillVal = fill;
        Start   = 1'b1;
        @(posedge Clk);
        #1;
        Start   = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic mode, input logic [7:0] src,
                                 input logic [7:0] dst, input logic [7:0] len, input logic [7:0] fill,
                                 input int restart_at, input logic [7:0] restart_dst,
                                 input logic hammer, input logic [7:0] hammer_addr);
        int   cycles;
        int   busy_cycles;
        int   wr_start;
        int   exp_done;
        logic seen;
        wr_start = write_count;
        startCmd(mode, src, dst, len, fill);
        cycles      = 1;
        busy_cycles = 0;
        seen        = 1'b0;
        while (cycles < 700) begin
            if (cycles == restart_at) begin
                Start   = 1'b1;
                Mode    = ~mode;
                SrcAddr = ~src;
                DstAddr = restart_dst;
                Len     = len + 8'd3;
                FillVal = ~fill;
            end else begin
                Start = 1'b0;
            end
            if (hammer) begin
                CpuAddr    = hammer_addr;
                CpuDataIn  = 8'h77;
                CpuWriteEn = !Done;
            end
            if (Busy) busy_cycles++;
            if (Done) begin
                seen = 1'b1;
                break;
            end
            @(posedge Clk);
            #1;
            cycles++;
        end
        if (len == 8'd0)
            exp_done = 1;
        else if (mode)
            exp_done = int'(len) + 1;
        else
            exp_done = 2 * int'(len) + 1;
        checkOutput({tag, " done seen"}, 32'(seen), 32'd1);
        checkOutput({tag, " done cycle"}, 32'(cycles), 32'(exp_done));
        checkOutput({tag, " busy cycles"}, 32'(busy_cycles), 32'(exp_done - 1));
        checkOutput({tag, " write count"}, 32'(write_count - wr_start), 32'(len));
        modelCommand(mode, src, dst, fill, int'(len));
        @(posedge Clk);
        #1;
        Start      = 1'b0;
        CpuWriteEn = 1'b0;
        checkOutput({tag, " busy after done"}, 32'(Busy), 32'd0);
        checkOutput({tag, " done one cycle"}, 32'(Done), 32'd0);
        checkMemory(tag);
    endtask

    initial begin
        int          wr_start;
        logic [7:0]  v;
        logic        rmode;
        logic [7:0]  rsrc, rdst, rlen, rfill;

        Reset_n    = 1'b0;
        Start      = 1'b0;
        Mode       = 1'b0;
        SrcAddr    = '0;
        DstAddr    = '0;
        Len        = '0;
        FillVal    = '0;
        CpuAddr    = 8'h33;
        CpuWriteEn = 1'b0;
        CpuDataIn  = 8'h00;

        #1;
        checkOutput("reset busy", 32'(Busy), 32'd0);
        checkOutput("reset done", 32'(Done), 32'd0);
        checkOutput("reset addr follows cpu", 32'(MemAddr), 32'h33);
        checkOutput("reset we low", 32'(MemWriteEn), 32'd0);
        CpuWriteEn = 1'b1;
        #1;
        checkOutput("reset we follows cpu", 32'(MemWriteEn), 32'd1);
        CpuWriteEn = 1'b0;
        #6;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int k = 0; k < 256; k++) begin
            v          = 8'($urandom);
            CpuAddr    = 8'(k);
            CpuDataIn  = v;
            CpuWriteEn = 1'b1;
            ref_mem[k] = v;
            @(posedge Clk);
            #1;
        end
        CpuWriteEn = 1'b0;
        checkMemory("preload");

        CpuAddr    = 8'h10;
        CpuDataIn  = 8'hA5;
        CpuWriteEn = 1'b1;
        #1;
        checkOutput("idle store we", 32'(MemWriteEn), 32'd1);
        checkOutput("idle store addr", 32'(MemAddr), 32'h10);
        checkOutput("idle store data", 32'(MemDataIn), 32'hA5);
        checkOutput("idle busy", 32'(Busy), 32'd0);
        @(posedge Clk);
        #1;
        CpuWriteEn = 1'b0;
        ref_mem[8'h10] = 8'hA5;
        #1;
        checkOutput("idle load we", 32'(MemWriteEn), 32'd0);
        checkOutput("idle load data", 32'(CpuDataOut), 32'hA5);

        applyStimulus("copy", 1'b0, 8'd52, 8'd100, 8'd9, 8'h00, -1, 8'h00, 1'b0, 8'h00);
        applyStimulus("fill wrap", 1'b1, 8'h00, 8'hFE, 8'd4, 8'h3C, -1, 8'h00, 1'b0, 8'h00);
        applyStimulus("len0", 1'b0, 8'd10, 8'd20, 8'd0, 8'h00, -1, 8'h00, 1'b0, 8'h00);
        applyStimulus("restart busy", 1'b0, 8'd30, 8'd130, 8'd6, 8'h00, 3, 8'd230, 1'b0, 8'h00);
        applyStimulus("restart done", 1'b1, 8'd0, 8'd70, 8'd3, 8'h5A, 4, 8'd90, 1'b0, 8'h00);
        applyStimulus("cpu blocked", 1'b1, 8'd0, 8'd150, 8'd10, 8'hC3, -1, 8'h00, 1'b1, 8'h05);

        wr_start = write_count;
        startCmd(1'b0, 8'd20, 8'd200, 8'd8, 8'h00);
        repeat (6) begin
            @(posedge Clk);
            #1;
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(Busy), 32'd0);
        checkOutput("abort done", 32'(Done), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        checkOutput("abort write count", 32'(write_count - wr_start), 32'd3);
        modelCommand(1'b0, 8'd20, 8'd200, 8'h00, 3);
        checkMemory("abort");
        applyStimulus("after abort", 1'b0, 8'd40, 8'd60, 8'd5, 8'h00, -1, 8'h00, 1'b0, 8'h00);

        for (int n = 0; n < 6; n++) begin
            rmode = 1'($urandom);
            rsrc  = 8'($urandom);
            rdst  = 8'($urandom);
            rlen  = 8'($urandom_range(0, 40));
            rfill = 8'($urandom);
            applyStimulus($sformatf("rand%0d", n), rmode, rsrc, rdst, rlen, rfill, -1, 8'h00, 1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
